// File: rtl/synth_params_pkg.sv
// Shared defaults and FSM encodings for the oscillator phase-accumulator slice.
// Downstream stages (sine LUT, mixer) import the same values so tag widths agree.
package synth_params;

  localparam int VOICES  = 8;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 11;
  localparam int LUT_LAT = 3;
  localparam int VIDX_W  = $clog2(VOICES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/voice_tag_delay.sv
// Fixed-depth shift register for {valid, voice} tags, cleared by async reset.
// Shifts every clock so the tag stays locked to a fixed-latency datapath.
module voice_tag_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  import synth_params::*;

  logic [WIDTH-1:0] tag_sr [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      tag_sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  assign dout = tag_sr[DEPTH-1];

endmodule

// File: rtl/osc_phase_accumulator.sv
// Time-multiplexed multi-voice NCO: one voice per clock per frame, emitting the
// sine LUT address and a voice tag delayed to line up with the LUT output.
module osc_phase_accumulator #(
  parameter int VOICES  = synth_params::VOICES,
  parameter int PHASE_W = synth_params::PHASE_W,
  parameter int ADDR_W  = synth_params::ADDR_W,
  parameter int LUT_LAT = synth_params::LUT_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      inc_we,
  input  logic [$clog2(VOICES)-1:0] inc_voice,
  input  logic [PHASE_W-1:0]        inc_data,
  input  logic [VOICES-1:0]         key_on,
  output logic [ADDR_W-1:0]         addr_out,
  output logic                      addr_valid,
  output logic [$clog2(VOICES)-1:0] addr_voice,
  output logic                      lut_valid,
  output logic [$clog2(VOICES)-1:0] lut_voice,
  output logic                      busy,
  output logic                      frame_overrun
);
  import synth_params::*;

  localparam int                 VOICE_W    = $clog2(VOICES);
  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(VOICES - 1);

  function automatic logic [ADDR_W-1:0] phase_to_addr(input logic [PHASE_W-1:0] ph);
    return ph[PHASE_W-1 -: ADDR_W];
  endfunction

  logic [0:0]         state_p0;
  logic [VOICE_W-1:0] vcnt_p0;
  logic               run_p0;

  logic [PHASE_W-1:0] phase_mem [VOICES];
  logic [PHASE_W-1:0] inc_mem   [VOICES];
  logic [VOICES-1:0]  pending;

  logic [PHASE_W-1:0] phase_rd_p0;
  logic [PHASE_W-1:0] inc_rd_p0;
  logic               pend_rd_p0;
  logic [PHASE_W-1:0] phase_nxt_p0;
  logic [VOICES-1:0]  pend_clr_p0;

  logic [ADDR_W-1:0]  addr_p1;
  logic               vld_p1;
  logic [VOICE_W-1:0] voice_p1;
  logic               ovr_p1;
  logic [VOICE_W:0]   tag_lut;

  // ---- p0: sweep sequencer and per-voice read/modify ----
  assign run_p0 = (state_p0 == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= ST_IDLE;
      vcnt_p0  <= '0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (frame_start) begin
            state_p0 <= ST_RUN;
            vcnt_p0  <= '0;
          end
        end
        ST_RUN: begin
          if (vcnt_p0 == LAST_VOICE) begin
            state_p0 <= ST_IDLE;
          end
          vcnt_p0 <= vcnt_p0 + 1'b1;
        end
        default: begin
          state_p0 <= ST_IDLE;
          vcnt_p0  <= '0;
        end
      endcase
    end
  end

  // Single read port per array, addressed by the sweep counter.
  assign phase_rd_p0 = phase_mem[vcnt_p0];
  assign inc_rd_p0   = inc_mem[vcnt_p0];
  assign pend_rd_p0  = pending[vcnt_p0];

  // A pending key-on restarts the voice: it emits address 0 and lands on inc.
  assign phase_nxt_p0 = pend_rd_p0 ? inc_rd_p0 : (phase_rd_p0 + inc_rd_p0);

  always_comb begin
    pend_clr_p0 = '0;
    if (run_p0 && pend_rd_p0) begin
      pend_clr_p0[vcnt_p0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        phase_mem[i] <= '0;
      end
    end else if (run_p0) begin
      phase_mem[vcnt_p0] <= phase_nxt_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        inc_mem[i] <= '0;
      end
    end else if (inc_we) begin
      inc_mem[inc_voice] <= inc_data;
    end
  end

  // Set has priority over clear so a key-on during the voice's own slot is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~pend_clr_p0) | key_on;
    end
  end

  // ---- p1: registered LUT address, voice tag and overrun strobe ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_p1  <= '0;
      vld_p1   <= 1'b0;
      voice_p1 <= '0;
      ovr_p1   <= 1'b0;
    end else begin
      vld_p1 <= run_p0;
      ovr_p1 <= run_p0 && frame_start;
      if (run_p0) begin
        addr_p1  <= pend_rd_p0 ? '0 : phase_to_addr(phase_rd_p0);
        voice_p1 <= vcnt_p0;
      end
    end
  end

  assign addr_out      = addr_p1;
  assign addr_valid    = vld_p1;
  assign addr_voice    = voice_p1;
  assign frame_overrun = ovr_p1;
  assign busy          = run_p0;

  // ---- p1 + LUT_LAT: tag aligned with the sine LUT read data ----
  voice_tag_delay #(
    .DEPTH (LUT_LAT),
    .WIDTH (VOICE_W + 1)
  ) u_tag_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({vld_p1, voice_p1}),
    .dout  (tag_lut)
  );

  assign lut_valid = tag_lut[VOICE_W];
  assign lut_voice = tag_lut[VOICE_W-1:0];

endmodule
